// File: rtl/fifo_param_fwft_pkg.sv
// Shared definitions for the parametrised FWFT channel FIFO: storage style names
// and width helpers for the occupancy counter and storage address.
package fifo_pkg;

  localparam string FIFO_SHIFTREG = "shiftreg";
  localparam string FIFO_RAM      = "ram";

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_param_fwft_storage.sv
// Data storage for the FWFT FIFO: either a shift-in register array read through a
// mux, or a circular buffer with asynchronous read. Contents are never reset.
module fifo_param_fwft_storage
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 5,
  parameter string MEM_STYLE  = FIFO_SHIFTREG,
  localparam int   ADDR_W     = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [ADDR_W-1:0]     waddr,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (MEM_STYLE == FIFO_RAM) begin : g_ram
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
      end

      assign dout = mem[raddr];
    end else begin : g_shiftreg
      logic [DATA_WIDTH-1:0] slot [DEPTH];
      logic                  unused_waddr;

      // Newest word enters slot 0; the oldest sits at slot[count-1].
      always_ff @(posedge clk) begin
        if (we) begin
          slot[0] <= din;
          for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
        end
      end

      assign dout         = slot[raddr];
      assign unused_waddr = ^waddr;
    end
  endgenerate

endmodule

// File: rtl/fifo_param_fwft.sv
// Parametrised first-word-fall-through channel FIFO with ce-qualified handshake,
// occupancy count, registered almost flags and sticky overflow/underflow errors.
module fifo_param_fwft
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 5,
  parameter string MEM_STYLE  = FIFO_SHIFTREG,
  parameter int    AF_MARGIN  = 1,
  parameter int    AE_MARGIN  = 1,
  localparam int   CNT_W      = fifo_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_W-1:0]      if_num_data,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int              ADDR_W   = fifo_addr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  count_m1;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] raddr;
  logic              wr_req;
  logic              rd_req;
  logic              push;
  logic              pop;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Push and pop are qualified by the registered flags, so a blocked request never
  // moves the count past 0 or DEPTH.
  always_comb begin
    wr_req    = if_write & if_write_ce;
    rd_req    = if_read & if_read_ce;
    push      = wr_req & if_full_n;
    pop       = rd_req & if_empty_n;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  always_comb begin
    count_m1 = count - CNT_W'(1);
    raddr    = rd_ptr;
    if (MEM_STYLE != FIFO_RAM) raddr = count_m1[ADDR_W-1:0];
  end

  // Flags are registered from the next count, keeping inputs off the flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count             <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      if_empty_n        <= 1'b0;
      if_full_n         <= 1'b1;
      if_almost_full_n  <= 1'b1;
      if_almost_empty_n <= 1'b0;
      err_overflow      <= 1'b0;
      err_underflow     <= 1'b0;
    end else begin
      count             <= count_nxt;
      if_empty_n        <= (count_nxt != '0);
      if_full_n         <= (count_nxt != FULL_LVL);
      if_almost_full_n  <= !(count_nxt >= AF_LVL);
      if_almost_empty_n <= !(count_nxt <= AE_LVL);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (wr_req && !if_full_n)  err_overflow  <= 1'b1;
      if (rd_req && !if_empty_n) err_underflow <= 1'b1;
    end
  end

  assign if_num_data = count;

  fifo_param_fwft_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MEM_STYLE  (MEM_STYLE)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .din   (if_din),
    .raddr (raddr),
    .waddr (wr_ptr),
    .dout  (if_dout)
  );

endmodule

// File: tb/tb_fifo_param_fwft.sv
// Directed bench for fifo_param_fwft: a shiftreg DEPTH=5 and a ram DEPTH=6 instance
// share one stimulus stream, each checked against its own expected column.
module tb_fifo_param_fwft;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       wr, wr_ce, rd, rd_ce;

  logic [7:0] dout0, dout1;
  logic [2:0] nd0, nd1;
  logic       fn0, fn1, en0, en1, afn0, afn1, aen0, aen1, ovf0, ovf1, udf0, udf1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_param_fwft #(.DATA_WIDTH(8), .DEPTH(5), .MEM_STYLE("shiftreg")) u_sr (
    .clk(clk), .reset(reset), .if_din(din), .if_write(wr), .if_write_ce(wr_ce),
    .if_full_n(fn0), .if_read(rd), .if_read_ce(rd_ce), .if_dout(dout0),
    .if_empty_n(en0), .if_num_data(nd0), .if_almost_full_n(afn0),
    .if_almost_empty_n(aen0), .err_overflow(ovf0), .err_underflow(udf0)
  );

  fifo_param_fwft #(.DATA_WIDTH(8), .DEPTH(6), .MEM_STYLE("ram")) u_ram (
    .clk(clk), .reset(reset), .if_din(din), .if_write(wr), .if_write_ce(wr_ce),
    .if_full_n(fn1), .if_read(rd), .if_read_ce(rd_ce), .if_dout(dout1),
    .if_empty_n(en1), .if_num_data(nd1), .if_almost_full_n(afn1),
    .if_almost_empty_n(aen1), .err_overflow(ovf1), .err_underflow(udf1)
  );

  typedef struct {
    logic       rst, w, r;
    logic [7:0] d;
    int         c0, c1;
    logic [7:0] d0, d1;
    logic       o0, o1, u0, u1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, w, r, input logic [7:0] d, input int c0, c1,
                     input logic [7:0] d0, d1, input logic o0, o1, u0, u1);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.d = d; v.c0 = c0; v.c1 = c1;
    v.d0 = d0; v.d1 = d1; v.o0 = o0; v.o1 = o1; v.u0 = u0; v.u1 = u1;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int idx, input int depth, input int c,
                         input logic [7:0] d, input logic o, u,
                         input logic [2:0] nd, input logic en, fn, afn, aen,
                         input logic [7:0] dq, input logic ovf, udf);
    chk({tag, ".num_data"}, idx, 32'(nd), 32'(c));
    chk({tag, ".empty_n"}, idx, 32'(en), 32'(c != 0));
    chk({tag, ".full_n"}, idx, 32'(fn), 32'(c != depth));
    chk({tag, ".almost_full_n"}, idx, 32'(afn), 32'(!(c >= depth - 1)));
    chk({tag, ".almost_empty_n"}, idx, 32'(aen), 32'(!(c <= 1)));
    chk({tag, ".err_overflow"}, idx, 32'(ovf), 32'(o));
    chk({tag, ".err_underflow"}, idx, 32'(udf), 32'(u));
    if (c != 0) chk({tag, ".dout"}, idx, 32'(dq), 32'(d));
  endtask

  task automatic step(input logic rst, w, wce, r, rce, input logic [7:0] d);
    @(negedge clk);
    reset = rst; wr = w; wr_ce = wce; rd = r; rd_ce = rce; din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seq0(input int j);
    return (j < 3) ? 8'(8'hA2 + j) : 8'(8'hB0 + j - 3);
  endfunction

  function automatic logic [7:0] seq1(input int j);
    return (j < 4) ? 8'(8'hA2 + j) : 8'(8'hB0 + j - 4);
  endfunction

  initial begin
    reset = 1'b1; wr = 1'b0; wr_ce = 1'b1; rd = 1'b0; rd_ce = 1'b1; din = 8'h00;

    //  rst w r din   c0 c1 d0     d1     o0 o1 u0 u1
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA0, 1, 1, 8'hA0, 8'hA0, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA1, 2, 2, 8'hA0, 8'hA0, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA2, 3, 3, 8'hA0, 8'hA0, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA3, 4, 4, 8'hA0, 8'hA0, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA4, 5, 5, 8'hA0, 8'hA0, 0, 0, 0, 0);
    add(0, 1, 0, 8'hA5, 5, 6, 8'hA0, 8'hA0, 1, 0, 0, 0);
    add(0, 1, 0, 8'hFF, 5, 6, 8'hA0, 8'hA0, 1, 1, 0, 0);
    add(0, 1, 1, 8'hEE, 4, 5, 8'hA1, 8'hA1, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 3, 4, 8'hA2, 8'hA2, 1, 1, 0, 0);
    for (int j = 1; j <= 10; j++)
      add(0, 1, 1, 8'(8'hB0 + j - 1), 3, 4, seq0(j), seq1(j), 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 2, 3, 8'hB8, 8'hB7, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 1, 2, 8'hB9, 8'hB8, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 0, 1, 8'h00, 8'hB9, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1);
    add(0, 1, 1, 8'h55, 1, 1, 8'h55, 8'h55, 1, 1, 1, 1);
    add(0, 1, 0, 8'h66, 2, 2, 8'h55, 8'h55, 1, 1, 1, 1);
    add(0, 1, 0, 8'h77, 3, 3, 8'h55, 8'h55, 1, 1, 1, 1);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 8'h12, 1, 1, 8'h12, 8'h12, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].w, 1'b1, vq[i].r, 1'b1, vq[i].d);
      chk_dut("sr", i, 5, vq[i].c0, vq[i].d0, vq[i].o0, vq[i].u0,
              nd0, en0, fn0, afn0, aen0, dout0, ovf0, udf0);
      chk_dut("ram", i, 6, vq[i].c1, vq[i].d1, vq[i].o1, vq[i].u1,
              nd1, en1, fn1, afn1, aen1, dout1, ovf1, udf1);
    end

    // Clock-enables low: requests are invisible, even a read of a nonempty FIFO.
    step(0, 1, 0, 1, 0, 8'h99);
    chk_dut("sr.ce_off", 100, 5, 1, 8'h12, 0, 0, nd0, en0, fn0, afn0, aen0, dout0, ovf0, udf0);
    chk_dut("ram.ce_off", 100, 6, 1, 8'h12, 0, 0, nd1, en1, fn1, afn1, aen1, dout1, ovf1, udf1);

    // Write ce off, read ce on: only the pop happens.
    step(0, 1, 0, 1, 1, 8'h99);
    chk_dut("sr.rd_only", 101, 5, 0, 8'h00, 0, 0, nd0, en0, fn0, afn0, aen0, dout0, ovf0, udf0);
    chk_dut("ram.rd_only", 101, 6, 0, 8'h00, 0, 0, nd1, en1, fn1, afn1, aen1, dout1, ovf1, udf1);

    // Read ce off on empty must not flag underflow; ce on must.
    step(0, 0, 1, 1, 0, 8'h00);
    chk("sr.udf_ce_off", 102, 32'(udf0), 32'd0);
    chk("ram.udf_ce_off", 102, 32'(udf1), 32'd0);
    step(0, 0, 1, 1, 1, 8'h00);
    chk("sr.udf_ce_on", 103, 32'(udf0), 32'd1);
    chk("ram.udf_ce_on", 103, 32'(udf1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
